matmul_core: RTL and testbench
==============================

// Module: matmul_core
// PURPOSE
//  Sequential NxN signed matrix-multiply engine, directly downstream of the APB register block.
//  The register block holds operand matrices A and B and pulses start; this core reads A/B
//  through a synchronous read port, computes C = A x B with one multiply-accumulate (MAC)
//  per cycle, writes C back element by element and pulses done.
// PARAMETERS
//  N       4   matrix dimension (square NxN); N >= 2
//  DATA_W  8   signed operand width, A and B elements
//  ACC_W   32  signed accumulator and result width; ACC_W >= 2*DATA_W
//  AW      $clog2(N*N)  element address width (derived localparam, not overridable)
// PORTS
//  clk        in   1       single clock; all logic on its rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  clr        in   1       synchronous abort; returns to IDLE, no done pulse
//  busy       out  1       high in every state except IDLE
//  done       out  1       1-cycle pulse when all of C is written
//  rd_en      out  1       operand read strobe
//  a_addr     out  AW      A element index, i*N+k
//  b_addr     out  AW      B element index, k*N+j
//  a_rdata    in   DATA_W  A element data, valid the cycle after rd_en
//  b_rdata    in   DATA_W  B element data, valid the cycle after rd_en
//  c_wr_en    out  1       result write strobe
//  c_addr     out  AW      C element index, i*N+j
//  c_wdata    out  ACC_W   result element
//  sat_flag   out  1       sticky saturation indicator (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//   - all outputs 0; state IDLE; i, j, k and acc cleared.
//   - reset mid-operation abandons the job: no further writes and no done.
//  FSM states: IDLE -> RD -> DRAIN -> WR -> (RD | FIN) -> IDLE.
//  IDLE:
//   - start=1 -> RD, with i=j=k=0 and acc=0.
//  RD (N cycles):
//   - rd_en=1; k counts 0..N-1.
//   - From the 2nd RD cycle, acc += a_rdata*b_rdata for element k-1.
//   - When k=N-1 -> DRAIN.
//  DRAIN:
//   - rd_en=0; accumulate the final product (k=N-1).
//  WR:
//   - c_wr_en=1, c_addr=i*N+j, c_wdata=acc.
//   - Then step j (row-major: j wraps at N-1 and increments i), clear acc and k -> RD.
//   - After element (N-1,N-1) -> FIN.
//  FIN:
//   - done=1 for exactly one cycle -> IDLE.
//  Timing:
//   - Each element takes N+2 cycles.
//   - done is high N*N*(N+2) rising edges after the edge that sampled start
//     (N=4: 96 edges).
//   - Exactly N*N c_wr_en pulses per job.
//  Arithmetic:
//   - Product is full signed 2*DATA_W, sign-extended to ACC_W.
//   - Accumulation is two's-complement in ACC_W bits.
//  Boundaries:
//   - start while busy is ignored (no restart, no queueing).
//   - start and clr together in IDLE: clr wins, stay IDLE.
//   - clr in any state: next cycle IDLE, busy=0, acc cleared, no done;
//     writes already issued stand.
//   - Outputs (rd_en, a/b_addr, c_wr_en, c_addr, c_wdata, done, busy) are registered;
//     addresses and c_wdata hold their last value when their strobe is low.
// CONFIGURATION
//  Macro MATMUL_CORE_SAT_EN.
//  Defined:
//   - Each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   - Any clamp sets sat_flag; it stays set until the next accepted start or reset.
//  Undefined:
//   - Accumulation wraps modulo 2^ACC_W.
//   - sat_flag is tied to 0.
// STRUCTURE
//  matmul_pkg holds:
//   - the state enum (IDLE, RD, DRAIN, WR, FIN);
//   - default N/DATA_W/ACC_W constants;
//   - an index-to-address helper function.
//  Sub-module matmul_mac holds the signed multiply, sign-extension, and the accumulate with
//  optional saturation; it has clear and enable inputs. Counters and the FSM live in
//  matmul_core.
// TESTING
//  1. A = identity, B[r][c] = r*4+c (N=4) -> C == B; 16 writes, c_addr 0..15 in order;
//     done 96 edges after start.
//  2. A = B = all 127, ACC_W=32 -> every C = 64516; sat_flag=0.
//  3. A = all -128, B = all 127 -> every C = -65024.
//  4. A = B = all 127, ACC_W=16 -> with SAT_EN every C = 32767 and sat_flag=1;
//     without SAT_EN every C = -1020 and sat_flag=0.
//  5. start re-pulsed at cycle 10 of a job -> ignored; done timing unchanged, still 16 writes.
//  6. rst_n low at cycle 40 -> all outputs 0 the same cycle; no done.
//     Separately, clr at cycle 40 -> busy=0 next cycle, no done, no further writes;
//     a later start runs cleanly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul_core engine: FSM state encoding,
// default geometry and the row/column to linear element address helper.
package matmul_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DRAIN,
    S_WR,
    S_FIN
  } state_t;

  // Row-major linear index of element (row, col) in an n x n matrix.
  function automatic int idx2addr(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate lane for matmul_core. Macro MATMUL_CORE_SAT_EN
// selects saturating accumulation; otherwise the sum wraps modulo 2^ACC_W.
module matmul_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_nxt,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_sum;
  logic                       ovf;

  assign prod   = a * b;
  assign prod_x = ACC_W'(prod);

`ifdef MATMUL_CORE_SAT_EN
  // One guard bit exposes signed overflow of the ACC_W-bit sum.
  logic signed [ACC_W:0] sum;

  assign sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_x);
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_sum = sum[ACC_W-1:0];
    if (ovf)
      acc_sum = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_sum = acc_q + prod_x;
  assign ovf     = 1'b0;
`endif

  assign sat = en & ~clr & ovf;

  always_comb begin
    acc_nxt = acc_q;
    if (clr)
      acc_nxt = '0;
    else if (en)
      acc_nxt = acc_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else
      acc_q <= acc_nxt;
  end

endmodule

// File: rtl/matmul_core.sv
// Sequential NxN signed matrix multiply: one MAC per cycle over a synchronous
// A/B read port, C written element by element. Option: MATMUL_CORE_SAT_EN.
module matmul_core
  import matmul_pkg::*;
#(
  parameter int  N      = N_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  ACC_W  = ACC_W_DEF,
  localparam int AW     = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     a_addr,
  output logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              c_wr_en,
  output logic [AW-1:0]     c_addr,
  output logic [ACC_W-1:0]  c_wdata,
  output logic              sat_flag
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, j_q, k_q;
  logic [CW-1:0]   i_d, j_d, k_d;
  logic            acc_clr, acc_en;
  logic            start_acc;
  logic            mac_sat;
  logic            sat_q;
  logic [ACC_W-1:0] acc_nxt;

  assign start_acc = (state_q == S_IDLE) && start && !clr;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
        end
      end
      S_RD: begin
        // Read data lags the address by one cycle, so RD k consumes term k-1.
        acc_en = (k_q != '0);
        if (k_q == LAST)
          state_d = S_DRAIN;
        else
          k_d = k_q + CW'(1);
      end
      S_DRAIN: begin
        acc_en  = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        acc_clr = 1'b1;
        k_d     = '0;
        if (i_q == LAST && j_q == LAST) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RD;
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + CW'(1);
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
      acc_clr = 1'b1;
      acc_en  = 1'b0;
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .a       (a_rdata),
    .b       (b_rdata),
    .acc_nxt (acc_nxt),
    .sat     (mac_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Outputs are registered from next-state values so strobes align with states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_wr_en <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_FIN);
      rd_en   <= (state_d == S_RD);
      c_wr_en <= (state_d == S_WR);
      if (state_d == S_RD) begin
        a_addr <= AW'(idx2addr(int'(i_d), int'(k_d), N));
        b_addr <= AW'(idx2addr(int'(k_d), int'(j_d), N));
      end
      if (state_d == S_WR) begin
        c_addr  <= AW'(idx2addr(int'(i_d), int'(j_d), N));
        c_wdata <= acc_nxt;
      end
    end
  end

  // Without saturation the MAC never reports a clamp, so this stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_q <= 1'b0;
    else if (start_acc)
      sat_q <= 1'b0;
    else if (mac_sat)
      sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;

endmodule

// File: tb/tb_matmul_core.sv
// Self-checking bench for matmul_core: 32-bit and 16-bit accumulator instances
// run side by side against a plain-arithmetic reference of C = A x B.
module tb_matmul_core;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  logic          busy, done, rd_en, c_wr_en, sat_flag;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_rdata = '0, b_rdata = '0;
  logic [31:0]   c_wdata;

  logic          busy_n, done_n, rd_en_n, c_wr_en_n, sat_flag_n;
  logic [AW-1:0] a_addr_n, b_addr_n, c_addr_n;
  logic [DW-1:0] a_rdata_n = '0, b_rdata_n = '0;
  logic [15:0]   c_wdata_n;

  int A[16];
  int B[16];

  int n_chk = 0;
  int n_err = 0;

  matmul_core #(.N(N), .DATA_W(DW), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .busy(busy), .done(done), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata), .sat_flag(sat_flag)
  );

  matmul_core #(.N(N), .DATA_W(DW), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .busy(busy_n), .done(done_n), .rd_en(rd_en_n),
    .a_addr(a_addr_n), .b_addr(b_addr_n), .a_rdata(a_rdata_n), .b_rdata(b_rdata_n),
    .c_wr_en(c_wr_en_n), .c_addr(c_addr_n), .c_wdata(c_wdata_n), .sat_flag(sat_flag_n)
  );

  // Synchronous operand memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= DW'(A[a_addr]);
      b_rdata <= DW'(B[b_addr]);
    end
    if (rd_en_n) begin
      a_rdata_n <= DW'(A[a_addr_n]);
      b_rdata_n <= DW'(B[b_addr_n]);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_elem(input int i, input int j, input int accw,
                                      output bit clamped);
    longint acc, s, lim;
    acc = 0;
    lim = longint'(1) << (accw - 1);
    clamped = 1'b0;
    for (int k = 0; k < N; k++) begin
      s = acc + longint'(A[i*N+k]) * longint'(B[k*N+j]);
`ifdef MATMUL_CORE_SAT_EN
      if (s > lim - 1) begin
        s = lim - 1;
        clamped = 1'b1;
      end else if (s < -lim) begin
        s = -lim;
        clamped = 1'b1;
      end
`else
      s = s & (2*lim - 1);
      if (s >= lim) s = s - 2*lim;
`endif
      acc = s;
    end
    return acc;
  endfunction

  task automatic fill_rand();
    for (int x = 0; x < 16; x++) begin
      A[x] = int'($urandom_range(0, 255)) - 128;
      B[x] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Runs one job; restart_at/clr_at/rst_at are cycle offsets after the start edge (-1 = none).
  task automatic run_job(input string name, input int restart_at, input int clr_at,
                         input int rst_at);
    longint e32[16], e16[16];
    bit s32, s16, cl;
    bit abort;
    int wr32, wr16, done_e;
    s32 = 0;
    s16 = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e32[i*N+j] = ref_elem(i, j, 32, cl);
        s32 |= cl;
        e16[i*N+j] = ref_elem(i, j, 16, cl);
        s16 |= cl;
      end
    abort  = (clr_at >= 0) || (rst_at >= 0);
    wr32   = 0;
    wr16   = 0;
    done_e = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk);
      start = (e == restart_at);
      if (c_wr_en) begin
        chk({name, ".c_addr32"}, longint'(c_addr), longint'(wr32));
        if (wr32 < 16) chk({name, ".c_data32"}, longint'($signed(c_wdata)), e32[wr32]);
        wr32++;
      end
      if (c_wr_en_n) begin
        chk({name, ".c_addr16"}, longint'(c_addr_n), longint'(wr16));
        if (wr16 < 16) chk({name, ".c_data16"}, longint'($signed(c_wdata_n)), e16[wr16]);
        wr16++;
      end
      if (done && done_e < 0) done_e = e;
      if (e == clr_at + 1 && clr_at >= 0) begin
        chk({name, ".busy_after_clr"}, longint'({busy, busy_n}), 0);
        clr = 1'b0;
      end
      if (e == clr_at) clr = 1'b1;
      if (e == rst_at + 1 && rst_at >= 0) rst_n = 1'b1;
      if (e == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, ".outs_in_reset"},
            longint'({busy, done, rd_en, c_wr_en, sat_flag, a_addr, b_addr, c_addr, c_wdata}), 0);
        chk({name, ".outs16_in_reset"},
            longint'({busy_n, done_n, rd_en_n, c_wr_en_n, sat_flag_n,
                      a_addr_n, b_addr_n, c_addr_n, c_wdata_n}), 0);
      end
      if (!abort && done_e >= 0 && e == done_e + 1) begin
        chk({name, ".done_pulse"}, longint'({done, done_n}), 0);
        chk({name, ".idle_after_done"}, longint'({busy, busy_n}), 0);
        break;
      end
    end
    if (!abort) begin
      chk({name, ".done_edge"}, longint'(done_e), 96);
      chk({name, ".writes32"}, longint'(wr32), 16);
      chk({name, ".writes16"}, longint'(wr16), 16);
      chk({name, ".sat32"}, longint'(sat_flag), longint'(s32));
      chk({name, ".sat16"}, longint'(sat_flag_n), longint'(s16));
    end else begin
      chk({name, ".no_done"}, longint'(done_e), -1);
      chk({name, ".writes_before_abort"}, longint'(wr32), 6);
      chk({name, ".writes16_before_abort"}, longint'(wr16), 6);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs32",
        longint'({busy, done, rd_en, c_wr_en, sat_flag, a_addr, b_addr, c_addr, c_wdata}), 0);
    chk("reset_outs16",
        longint'({busy_n, done_n, rd_en_n, c_wr_en_n, sat_flag_n,
                  a_addr_n, b_addr_n, c_addr_n, c_wdata_n}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r*N+c] = (r == c) ? 1 : 0;
        B[r*N+c] = r*4 + c;
      end
    run_job("identity", -1, -1, -1);

    for (int x = 0; x < 16; x++) begin A[x] = 127;  B[x] = 127; end
    run_job("max_pos", -1, -1, -1);

    for (int x = 0; x < 16; x++) begin A[x] = -128; B[x] = 127; end
    run_job("max_neg", -1, -1, -1);

    fill_rand();
    run_job("restart_ignored", 10, -1, -1);

    fill_rand();
    run_job("reset_abort", -1, -1, 40);

    fill_rand();
    run_job("clr_abort", -1, 40, -1);

    for (int t = 0; t < 3; t++) begin
      fill_rand();
      run_job("random", -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
